// File: rtl/aes_ct_collector.sv
// aes_ct_collector: capture stage behind the AES-lite byte encryptor.
// A rising edge on ct_ready captures ct_data into a show-ahead FIFO. The
// consumer drains the FIFO over a valid/ack handshake. The block also keeps a
// running XOR checksum of accepted bytes and a sticky flag for dropped bytes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ct_data, ct_ready   ciphertext byte and completion strobe (level)
//   clr                 clears overflow and checksum only
//   out_data, out_valid head-of-FIFO byte (00 while empty) and non-empty flag
//   out_ack             consumer accepts head when out_valid && out_ack
//   count, full, empty  occupancy (0..DEPTH) and decodes of it
//   overflow            sticky: a capture was dropped while full
//   checksum            XOR of accepted bytes since reset or clr
module aes_ct_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    ct_data,
  input  logic          ct_ready,
  input  logic          clr,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ack,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    checksum
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic            ct_prev_q, ct_prev_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      checksum_q, checksum_d;
  logic [7:0]      mem_q [DEPTH];

  logic capture, pop, push, drop;
  logic full_c, empty_c;

  // Occupancy decodes come from count so full and empty never alias.
  assign full_c  = (count_q == FULL_CNT);
  assign empty_c = (count_q == '0);

  // Handshake decode: a pop frees a slot in the same cycle, so a capture
  // at full is still accepted when the head is leaving.
  always_comb begin
    capture = ct_ready && !ct_prev_q;
    pop     = !empty_c && out_ack;
    push    = capture && (!full_c || pop);
    drop    = capture && full_c && !pop;
  end

  // Next-state for pointers, count, checksum and overflow.
  always_comb begin
    ct_prev_d  = ct_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    checksum_d = checksum_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // clr first, then this cycle's capture result layered on top.
    if (clr) begin
      overflow_d = 1'b0;
      checksum_d = 8'h00;
    end
    if (push) checksum_d = checksum_d ^ ct_data;
    if (drop) overflow_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct_prev_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      checksum_q <= 8'h00;
    end else begin
      ct_prev_q  <= ct_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      checksum_q <= checksum_d;
    end
  end

  // Storage is not reset; it is only observable through out_data when non-empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= ct_data;
  end

  assign out_data  = empty_c ? 8'h00 : mem_q[rd_ptr_q];
  assign out_valid = !empty_c;
  assign count     = count_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign overflow  = overflow_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_aes_ct_collector.sv
// Bench for aes_ct_collector: directed vector table, a wrap-around sequence,
// then randomized traffic against a queue-based reference model.
module tb_aes_ct_collector;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] ct_data;
  logic       ct_ready;
  logic       clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ack;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  aes_ct_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ct_data(ct_data), .ct_ready(ct_ready),
    .clr(clr), .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a byte queue plus checksum/overflow/previous-strobe.
  logic [7:0] mq[$];
  logic [7:0] m_cs;
  logic       m_ov;
  logic       m_prev;

  task automatic model_edge(input logic r, input logic rdy, input logic [7:0] d,
                            input logic c, input logic a);
    logic cap;
    if (!r) begin
      mq.delete();
      m_cs = 8'h00; m_ov = 1'b0; m_prev = 1'b0;
    end else begin
      cap = rdy && !m_prev;
      m_prev = rdy;
      if (mq.size() > 0 && a) void'(mq.pop_front());
      if (c) begin m_cs = 8'h00; m_ov = 1'b0; end
      if (cap) begin
        if (mq.size() < DEPTH) begin mq.push_back(d); m_cs = m_cs ^ d; end
        else m_ov = 1'b1;
      end
    end
  endtask

  // Drive inputs away from the edge, advance one clock, sample 1 time unit later.
  task automatic step(input logic r, input logic rdy, input logic [7:0] d,
                      input logic c, input logic a);
    rst_n = r; ct_ready = rdy; ct_data = d; clr = c; out_ack = a;
    model_edge(r, rdy, d, c, a);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_cnt, input logic [7:0] e_od,
                         input logic e_ov, input logic [7:0] e_cs);
    chk({tag, ".count"},     8'(count),     8'(e_cnt));
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(e_cnt != 0));
    chk({tag, ".empty"},     8'(empty),     8'(e_cnt == 0));
    chk({tag, ".full"},      8'(full),      8'(e_cnt == 3'(DEPTH)));
    chk({tag, ".out_data"},  out_data,      e_od);
    chk({tag, ".overflow"},  8'(overflow),  8'(e_ov));
    chk({tag, ".checksum"},  checksum,      e_cs);
  endtask

  typedef struct {
    logic       r;
    logic       rdy;
    logic [7:0] d;
    logic       c;
    logic       a;
    logic [2:0] cnt;
    logic [7:0] od;
    logic       ov;
    logic [7:0] cs;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic r, logic rdy, logic [7:0] d, logic c, logic a,
                             logic [2:0] cnt, logic [7:0] od, logic ov, logic [7:0] cs);
    vec_t t;
    t.r = r; t.rdy = rdy; t.d = d; t.c = c; t.a = a;
    t.cnt = cnt; t.od = od; t.ov = ov; t.cs = cs;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; ct_ready = 1'b0; ct_data = 8'h00; clr = 1'b0; out_ack = 1'b0;

    // r rdy data clr ack | count out_data ov checksum
    // Single capture, pop, ack while empty.
    vt.push_back(v(0,0,8'h00,0,0, 0,8'h00,0,8'h00));
    vt.push_back(v(1,1,8'hA5,0,0, 1,8'hA5,0,8'hA5));
    vt.push_back(v(1,0,8'h00,0,0, 1,8'hA5,0,8'hA5));
    vt.push_back(v(1,0,8'h00,0,1, 0,8'h00,0,8'hA5));
    vt.push_back(v(1,0,8'h00,0,1, 0,8'h00,0,8'hA5));
    // Held strobe yields one entry.
    vt.push_back(v(0,0,8'h00,0,0, 0,8'h00,0,8'h00));
    for (int i = 0; i < 5; i++) vt.push_back(v(1,1,8'h3C,0,0, 1,8'h3C,0,8'h3C));
    vt.push_back(v(1,0,8'h00,0,0, 1,8'h3C,0,8'h3C));
    // Fill, overflow, drain.
    vt.push_back(v(0,0,8'h00,0,0, 0,8'h00,0,8'h00));
    vt.push_back(v(1,1,8'h11,0,0, 1,8'h11,0,8'h11));
    vt.push_back(v(1,0,8'h00,0,0, 1,8'h11,0,8'h11));
    vt.push_back(v(1,1,8'h22,0,0, 2,8'h11,0,8'h33));
    vt.push_back(v(1,0,8'h00,0,0, 2,8'h11,0,8'h33));
    vt.push_back(v(1,1,8'h33,0,0, 3,8'h11,0,8'h00));
    vt.push_back(v(1,0,8'h00,0,0, 3,8'h11,0,8'h00));
    vt.push_back(v(1,1,8'h44,0,0, 4,8'h11,0,8'h44));
    vt.push_back(v(1,0,8'h00,0,0, 4,8'h11,0,8'h44));
    vt.push_back(v(1,1,8'h55,0,0, 4,8'h11,1,8'h44));
    vt.push_back(v(1,0,8'h00,0,1, 3,8'h22,1,8'h44));
    vt.push_back(v(1,0,8'h00,0,1, 2,8'h33,1,8'h44));
    vt.push_back(v(1,0,8'h00,0,1, 1,8'h44,1,8'h44));
    vt.push_back(v(1,0,8'h00,0,1, 0,8'h00,1,8'h44));
    // Push and pop together at full.
    vt.push_back(v(0,0,8'h00,0,0, 0,8'h00,0,8'h00));
    vt.push_back(v(1,1,8'h11,0,0, 1,8'h11,0,8'h11));
    vt.push_back(v(1,0,8'h00,0,0, 1,8'h11,0,8'h11));
    vt.push_back(v(1,1,8'h22,0,0, 2,8'h11,0,8'h33));
    vt.push_back(v(1,0,8'h00,0,0, 2,8'h11,0,8'h33));
    vt.push_back(v(1,1,8'h33,0,0, 3,8'h11,0,8'h00));
    vt.push_back(v(1,0,8'h00,0,0, 3,8'h11,0,8'h00));
    vt.push_back(v(1,1,8'h44,0,0, 4,8'h11,0,8'h44));
    vt.push_back(v(1,0,8'h00,0,0, 4,8'h11,0,8'h44));
    vt.push_back(v(1,1,8'h66,0,1, 4,8'h22,0,8'h22));
    vt.push_back(v(1,0,8'h00,0,1, 3,8'h33,0,8'h22));
    vt.push_back(v(1,0,8'h00,0,1, 2,8'h44,0,8'h22));
    vt.push_back(v(1,0,8'h00,0,1, 1,8'h66,0,8'h22));
    vt.push_back(v(1,0,8'h00,0,1, 0,8'h00,0,8'h22));
    // clr with accepted capture; ack at count 0 is not a pop.
    vt.push_back(v(1,1,8'h7E,1,1, 1,8'h7E,0,8'h7E));
    vt.push_back(v(1,0,8'h00,0,1, 0,8'h00,0,8'h7E));
    // Refill, then clr with a dropped capture.
    vt.push_back(v(1,1,8'h01,0,0, 1,8'h01,0,8'h7F));
    vt.push_back(v(1,0,8'h00,0,0, 1,8'h01,0,8'h7F));
    vt.push_back(v(1,1,8'h02,0,0, 2,8'h01,0,8'h7D));
    vt.push_back(v(1,0,8'h00,0,0, 2,8'h01,0,8'h7D));
    vt.push_back(v(1,1,8'h03,0,0, 3,8'h01,0,8'h7E));
    vt.push_back(v(1,0,8'h00,0,0, 3,8'h01,0,8'h7E));
    vt.push_back(v(1,1,8'h04,0,0, 4,8'h01,0,8'h7A));
    vt.push_back(v(1,0,8'h00,0,0, 4,8'h01,0,8'h7A));
    vt.push_back(v(1,1,8'h05,1,0, 4,8'h01,1,8'h00));
    vt.push_back(v(1,0,8'h00,1,0, 4,8'h01,0,8'h00));
    // Reset mid-drain; strobe already high when reset releases.
    vt.push_back(v(1,0,8'h00,0,1, 3,8'h02,0,8'h00));
    vt.push_back(v(0,0,8'h00,0,1, 0,8'h00,0,8'h00));
    vt.push_back(v(0,1,8'h9A,0,0, 0,8'h00,0,8'h00));
    vt.push_back(v(1,1,8'h9A,0,0, 1,8'h9A,0,8'h9A));

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].rdy, vt[i].d, vt[i].c, vt[i].a);
      chk_all($sformatf("vec%0d", i), vt[i].cnt, vt[i].od, vt[i].ov, vt[i].cs);
    end

    // Wrap-around: ten capture/drain pairs walk the pointers round twice.
    step(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(i), 0, 0);
      chk($sformatf("wrap%0d.out_data", i), out_data, 8'(i));
      chk($sformatf("wrap%0d.count", i), 8'(count), 8'd1);
      step(1, 0, 8'h00, 0, 1);
      chk($sformatf("wrap%0d.empty", i), 8'(empty), 8'd1);
    end
    chk("wrap.checksum", checksum, 8'h01);

    // Randomized traffic against the reference model.
    step(0, 0, 8'h00, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, rdy, c, a;
      logic [7:0] d;
      r   = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      d   = 8'($urandom);
      c   = ($urandom_range(0, 19) == 0);
      a   = ($urandom_range(0, 2) == 0);
      step(r, rdy, d, c, a);
      chk_all("rand", 3'(mq.size()), (mq.size() > 0) ? mq[0] : 8'h00, m_ov, m_cs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_ct_collector.md
# aes_ct_collector

Downstream capture stage for the AES-lite byte encryptor. Detects each completion strobe from the encryptor and stores the ciphertext byte in a small show-ahead FIFO. Bytes drain to a consumer over a valid/ack handshake. The block also keeps a running XOR checksum of accepted bytes and a sticky overflow flag for bytes lost while the FIFO was full.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width; derived, do not override

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- ct_data  in  8  ciphertext byte from encryptor; stable while ct_ready is high
- ct_ready  in  1  encryptor completion strobe; level, may stay high for more than one cycle
- clr  in  1  synchronous clear of overflow and checksum only; FIFO contents are kept
- out_data  out  8  head-of-FIFO byte; 8'h00 while empty
- out_valid  out  1  FIFO non-empty
- out_ack  in  1  consumer accepts head when out_valid && out_ack
- count  out  AW+1  stored entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; a capture was dropped
- checksum  out  8  XOR of all accepted bytes since reset or clr

## Operation
- Edge detect: register ct_prev <= ct_ready. A capture occurs in any cycle where ct_ready && !ct_prev. A level held high yields exactly one capture.
- Push: a capture is accepted when !full, or when full && pop in the same cycle. The accepted byte is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Drop: a capture while full && !pop is discarded. overflow is set to 1 and checksum is left unchanged.
- Pop: pop = out_valid && out_ack. On pop, rd_ptr increments modulo DEPTH. out_ack while empty is ignored.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together, or on neither
- Pointers wrap naturally; full and empty are decoded from count, not pointer equality.
- checksum: on each accepted push, checksum <= checksum ^ ct_data.
- clr:
  - overflow <= 0 and checksum <= 0.
  - With an accepted push in the same cycle, checksum <= ct_data.
  - With a dropped capture in the same cycle, overflow <= 1 (set wins over clear).
- out_data = mem[rd_ptr] when !empty, else 8'h00. This is a combinational mux from registered state, so no extra flop is needed.
- No internal FSM beyond the edge detector. Control is the FIFO pointer/count logic.

## Timing
- Reset (rst_n low at a clk edge) sets:
  - wr_ptr = 0, rd_ptr = 0, count = 0, ct_prev = 0
  - overflow = 0, checksum = 8'h00
  - empty = 1, full = 0, out_valid = 0, out_data = 8'h00
- Memory contents are not reset; they are unobservable while empty.
- Reset mid-operation discards all stored bytes. A ct_ready already high when reset releases counts as a rising edge and is captured in the first cycle out of reset, since ct_prev = 0.
- Capture latency: rising ct_ready sampled at edge N gives the write at edge N. With the FIFO previously empty, out_valid = 1 and out_data = byte after edge N, i.e. 1 cycle.
- Pop takes effect at the edge where out_valid && out_ack. The next entry, or empty, is visible after that edge.
- Full throughput: one push and one pop per cycle sustained. Simultaneous push and pop at count = DEPTH is accepted without overflow.
- At count = 0, simultaneous capture and out_ack: no pop occurs (out_valid was 0), and count becomes 1.
- clr is effective at the edge where it is sampled. It has no effect on count, pointers or out_*.

## Test plan
- Reset then single capture: ct_data = 8'hA5, ct_ready high 1 cycle -> after 1 edge out_valid = 1, out_data = A5, count = 1, checksum = A5. Pulse out_ack -> empty = 1, out_data = 00.
- Held strobe: ct_ready high 5 cycles with ct_data = 8'h3C -> exactly one entry, count = 1, checksum = 3C.
- Fill and overflow (DEPTH = 4): capture 11, 22, 33, 44 with out_ack = 0 -> full = 1, checksum = 44. Capture 55 -> overflow = 1, count = 4, checksum stays 44. Drain yields 11, 22, 33, 44 in order.
- Push+pop at full: full with 11..44, out_ack = 1 in the same cycle as capture of 66 -> overflow stays 0, count = 4. Drain yields 22, 33, 44, 66.
- Wrap-around: 10 capture/drain pairs with bytes 00..09 -> every byte emerges in order, pointers wrap twice, checksum = 01 (XOR of 00..09).
- clr interactions:
  - clr with a simultaneous accepted capture of 7E -> checksum = 7E, overflow = 0.
  - clr with a simultaneous dropped capture -> overflow = 1.
  - rst_n low for 1 cycle mid-drain -> count = 0, out_valid = 0 on the next cycle.
